crypto_wallet_rng_source: RTL and testbench
===========================================

Name: crypto_wallet_rng_source

Overview:
Entropy collector and conditioner that sits directly upstream of the random-number PIO input port: its rand_out drives that port's 32-bit in_port.
- Samples an asynchronous raw entropy bit (ring-oscillator output) on a rate strobe.
- De-biases the samples with a von Neumann corrector and packs accepted bits into 32-bit words.
- Optionally XOR-mixes each word with a Galois LFSR.
- Holds the last complete word stable for software reads, and runs a repetition-count health test.

Parameters:
WORD_W, 32, output word width (fixed at 32 for the PIO)
LFSR_SEED, 32'hACE12468, LFSR value after reset
MIX_EN, 1, 1 = XOR each word with the LFSR; 0 = raw von Neumann output
HEALTH_RUN_MAX, 32, consecutive identical raw samples that trip health_fail

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  collection enable (level)
sample_tick  in  1  one-cycle sampling strobe, clk domain
entropy_in  in  1  raw entropy bit, asynchronous to clk
rand_out  out  32  last complete conditioned word; feeds the PIO in_port
rand_valid  out  1  at least one word produced since reset and no health fault
health_fail  out  1  sticky repetition-count fault
word_count  out  16  words produced since reset, wraps at 2^16

Behaviour:
- Clocking/reset: one clock, clk. Reset is asynchronous and active-high, on port reset.
- Reset values: rand_out=0, rand_valid=0, health_fail=0, word_count=0, lfsr=LFSR_SEED, accumulator=0, bit count=0, FSM=WAIT_A, run length=0.
- Input sync: entropy_in passes a 2-flop synchronizer; s_bit is the synchronized value. Asynchronous-to-sync latency is 2 clk.
- Gating: sample_tick is acted on only when enable=1 and health_fail=0. A tick samples s_bit in that same cycle.
- FSM WAIT_A: on tick, a_bit <= s_bit; go to WAIT_B.
- FSM WAIT_B: on tick, go to WAIT_A.
  - If s_bit != a_bit: accept bit a_bit.
  - Otherwise discard the pair.
- Accepted bit: acc <= {acc[30:0], a_bit}; bit count increments.
- On the 32nd accepted bit, in the next cycle:
  - rand_out <= {acc[30:0], a_bit} ^ (MIX_EN ? lfsr : 0)
  - lfsr steps once
  - word_count increments
  - rand_valid <= 1
  - bit count <= 0
- Latency: rand_out updates 1 clk after the accepting tick. rand_out is held constant between updates.
- LFSR step (Galois): lfsr <= lfsr[0] ? ((lfsr>>1) ^ 32'h80200003) : (lfsr>>1). It advances only on word completion, so output is deterministic for test.
- Health test: on every gated tick, compare s_bit with the previous sample.
  - Equal: run_len increments, saturating. Different: run_len <= 1. The first tick after reset sets run_len=1.
  - When run_len reaches HEALTH_RUN_MAX: health_fail <= 1 (sticky until reset), rand_valid <= 0, acc and bit count cleared, FSM <= WAIT_A.
  - rand_out and word_count keep their last values.
- enable falling: the FSM returns to WAIT_A and acc, bit count and run_len clear in the next cycle. A partial word is discarded. rand_out, lfsr, word_count and rand_valid are held.
- Simultaneous health trip and 32nd accepted bit on the same tick: the fault wins; no word is produced.
- word_count wraps 16'hFFFF -> 0 without side effects.
- Reset asserted mid-word: all state returns to reset values immediately (asynchronous).

Decomposition:
- Package crypto_wallet_rng_pkg holds:
  - WORD_W
  - LFSR_MASK (32'h80200003)
  - default LFSR_SEED
  - FSM state enum {WAIT_A, WAIT_B}
  - the lfsr_step function
- One sub-module: crypto_wallet_sync_bit, a 2-flop synchronizer with asynchronous active-high reset to 0.

Test Plan:
1. Reset check: assert reset mid-activity -> rand_out=0, rand_valid=0, health_fail=0, word_count=0 asynchronously.
2. Raw word: MIX_EN=0, enable=1, 32 pairs (1,0) on ticks -> rand_out=32'hFFFFFFFF 1 clk after the 64th tick, rand_valid=1, word_count=1.
3. Discarded pairs: MIX_EN=0, interleave (0,0) and (1,1) pairs among 32 (0,1) pairs, never 32 identical samples in a row -> exactly one word, rand_out=0, word_count=1.
4. Mixing: MIX_EN=1, 32 pairs (0,1) -> rand_out=32'hACE12468; a further 32 pairs (0,1) -> rand_out=32'h56709234, word_count=2.
5. Health trip: hold entropy_in=1 for 32 ticks -> health_fail=1 and rand_valid=0 after the 32nd tick; subsequent (1,0) pairs do not change rand_out or word_count.
6. Enable drop: after 10 accepted bits drop enable for 3 clk, re-enable -> the word completes only after 32 further accepted bits; rand_out unchanged meanwhile.

Source files
------------

// File: rtl/crypto_wallet_rng_pkg.sv
// Shared constants, FSM state type and LFSR step for the RNG entropy source.
// Imported by the top and its synchronizer.
package crypto_wallet_rng_pkg;

    localparam int          WORD_W        = 32;
    localparam logic [31:0] LFSR_MASK     = 32'h80200003;
    localparam logic [31:0] LFSR_SEED_DEF = 32'hACE12468;

    typedef enum logic {
        WAIT_A = 1'b0,
        WAIT_B = 1'b1
    } vn_state_e;

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
    endfunction

endpackage

// File: rtl/crypto_wallet_rng_source_sync_bit.sv
// Two-flop synchronizer for the asynchronous ring-oscillator bit.
// Asynchronous active-high reset to 0.
module crypto_wallet_sync_bit (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);
    import crypto_wallet_rng_pkg::*;

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/crypto_wallet_rng_source.sv
// Entropy collector: von Neumann de-biasing, 32-bit packing, optional LFSR
// mixing and a sticky repetition-count health test.
module crypto_wallet_rng_source #(
    parameter int          WORD_W         = crypto_wallet_rng_pkg::WORD_W,
    parameter logic [31:0] LFSR_SEED      = crypto_wallet_rng_pkg::LFSR_SEED_DEF,
    parameter bit          MIX_EN         = 1'b1,
    parameter int          HEALTH_RUN_MAX = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              sample_tick,
    input  logic              entropy_in,
    output logic [WORD_W-1:0] rand_out,
    output logic              rand_valid,
    output logic              health_fail,
    output logic [15:0]       word_count
);
    import crypto_wallet_rng_pkg::*;

    localparam int CNT_W = $clog2(WORD_W);
    localparam int RUN_W = $clog2(HEALTH_RUN_MAX + 1);

    vn_state_e         r_state;
    logic              r_a_bit;
    logic              r_prev;
    logic [WORD_W-1:0] r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic [RUN_W-1:0]  r_run;
    logic [31:0]       r_lfsr;
    logic [WORD_W-1:0] r_rand;
    logic              r_valid;
    logic              r_fail;
    logic [15:0]       r_wc;

    logic              w_s_bit;
    logic              w_tick;
    logic              w_accept;
    logic              w_word_done;
    logic              w_trip;
    logic [RUN_W-1:0]  w_run_nxt;
    logic [WORD_W-1:0] w_acc_nxt;

    crypto_wallet_sync_bit u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (entropy_in),
        .o_q   (w_s_bit)
    );

    assign w_tick      = sample_tick & enable & ~r_fail;
    assign w_accept    = w_tick & (r_state == WAIT_B) & (w_s_bit != r_a_bit);
    assign w_acc_nxt   = {r_acc[WORD_W-2:0], r_a_bit};
    assign w_word_done = w_accept & (r_cnt == CNT_W'(WORD_W - 1));
    assign w_trip      = w_tick & (w_run_nxt == RUN_W'(HEALTH_RUN_MAX));

    // run length 0 means "no previous sample", so the next tick starts at 1
    always_comb begin
        w_run_nxt = RUN_W'(1);
        if (r_run != '0 && w_s_bit == r_prev) begin
            w_run_nxt = (r_run == RUN_W'(HEALTH_RUN_MAX)) ? r_run : r_run + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= WAIT_A;
            r_a_bit <= 1'b0;
            r_prev  <= 1'b0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_run   <= '0;
            r_lfsr  <= LFSR_SEED;
            r_rand  <= '0;
            r_valid <= 1'b0;
            r_fail  <= 1'b0;
            r_wc    <= 16'd0;
        end else if (!enable) begin
            r_state <= WAIT_A;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_run   <= '0;
        end else if (w_tick) begin
            r_run  <= w_run_nxt;
            r_prev <= w_s_bit;
            if (w_trip) begin
                r_fail  <= 1'b1;
                r_valid <= 1'b0;
                r_acc   <= '0;
                r_cnt   <= '0;
                r_state <= WAIT_A;
            end else if (r_state == WAIT_A) begin
                r_a_bit <= w_s_bit;
                r_state <= WAIT_B;
            end else begin
                r_state <= WAIT_A;
                if (w_accept) begin
                    r_acc <= w_acc_nxt;
                    if (w_word_done) begin
                        r_cnt   <= '0;
                        r_rand  <= w_acc_nxt ^ (MIX_EN ? r_lfsr : 32'h0);
                        r_lfsr  <= lfsr_step(r_lfsr);
                        r_wc    <= r_wc + 16'd1;
                        r_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end
        end
    end

    assign rand_out    = r_rand;
    assign rand_valid  = r_valid;
    assign health_fail = r_fail;
    assign word_count  = r_wc;

endmodule

// File: tb/tb_crypto_wallet_rng_source.sv
// Randomized bench for crypto_wallet_rng_source: raw and mixed instances
// share stimulus and are compared against a queue-based reference model.
module tb_crypto_wallet_rng_source;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        sample_tick = 1'b0;
    logic        entropy_in = 1'b0;

    logic [31:0] raw_out;
    logic        raw_valid;
    logic        raw_fail;
    logic [15:0] raw_wc;
    logic [31:0] mix_out;
    logic        mix_valid;
    logic        mix_fail;
    logic [15:0] mix_wc;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    crypto_wallet_rng_source #(.MIX_EN(1'b0)) u_raw (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .sample_tick (sample_tick),
        .entropy_in  (entropy_in),
        .rand_out    (raw_out),
        .rand_valid  (raw_valid),
        .health_fail (raw_fail),
        .word_count  (raw_wc)
    );

    crypto_wallet_rng_source #(.MIX_EN(1'b1)) u_mix (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .sample_tick (sample_tick),
        .entropy_in  (entropy_in),
        .rand_out    (mix_out),
        .rand_valid  (mix_valid),
        .health_fail (mix_fail),
        .word_count  (mix_wc)
    );

    // reference model state
    bit          m_en;
    bit          m_fail;
    bit          m_valid;
    bit [15:0]   m_wc;
    bit [31:0]   m_raw;
    bit [31:0]   m_mix;
    bit [31:0]   m_lfsr;
    bit          m_have_a;
    bit          m_a;
    bit          m_prev;
    int          m_run;
    bit          m_bits[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit [31:0] lfsr_next(input bit [31:0] v);
        return v[0] ? ((v >> 1) ^ 32'h80200003) : (v >> 1);
    endfunction

    task automatic m_reset();
        m_fail = 0; m_valid = 0; m_wc = 0;
        m_raw = 0; m_mix = 0; m_lfsr = 32'hACE12468;
        m_have_a = 0; m_run = 0; m_prev = 0;
        m_bits.delete();
    endtask

    task automatic m_drop();
        m_have_a = 0; m_run = 0;
        m_bits.delete();
    endtask

    task automatic m_tick(input bit b);
        bit [31:0] w;
        if (!m_en || m_fail) return;
        if (m_run == 0 || b != m_prev) m_run = 1;
        else if (m_run < 32) m_run++;
        m_prev = b;
        if (m_run == 32) begin
            m_fail = 1; m_valid = 0;
            m_have_a = 0; m_bits.delete();
            return;
        end
        if (!m_have_a) begin
            m_a = b; m_have_a = 1;
        end else begin
            m_have_a = 0;
            if (b != m_a) m_bits.push_back(m_a);
        end
        if (m_bits.size() == 32) begin
            w = 0;
            foreach (m_bits[i]) w = {w[30:0], m_bits[i]};
            m_raw = w;
            m_mix = w ^ m_lfsr;
            m_lfsr = lfsr_next(m_lfsr);
            m_wc++;
            m_valid = 1;
            m_bits.delete();
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".raw_out"}, raw_out, m_raw);
        chk({tag, ".mix_out"}, mix_out, m_mix);
        chk({tag, ".valid"}, {30'd0, raw_valid, mix_valid}, {30'd0, m_valid, m_valid});
        chk({tag, ".fail"}, {30'd0, raw_fail, mix_fail}, {30'd0, m_fail, m_fail});
        chk({tag, ".wc"}, {raw_wc, mix_wc}, {m_wc, m_wc});
    endtask

    task automatic do_tick(input bit b);
        @(negedge clk);
        entropy_in = b;
        repeat (2) @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        m_tick(b);
    endtask

    task automatic pair(input bit a, input bit b);
        do_tick(a);
        do_tick(b);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_reset();
    endtask

    task automatic drop_enable();
        @(negedge clk);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        enable = 1'b1;
        m_drop();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] save_out;
        logic [15:0] save_wc;
        bit          a;
        int          r;

        m_en = 1;
        m_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        enable = 1'b1;
        check_all("reset");

        // raw word of all ones
        for (int i = 0; i < 32; i++) pair(1'b1, 1'b0);
        check_all("ones");
        chk("ones.const", raw_out, 32'hFFFFFFFF);

        // asynchronous reset mid-word
        for (int i = 0; i < 5; i++) pair(1'b0, 1'b1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        m_reset();
        check_all("async_rst");
        @(negedge clk);
        reset = 1'b0;

        // discarded pairs interleaved among (0,1)
        for (int i = 0; i < 32; i++) begin
            r = $urandom_range(0, 2);
            if (r == 1) pair(1'b0, 1'b0);
            else if (r == 2) pair(1'b1, 1'b1);
            pair(1'b0, 1'b1);
            if (i == 30) check_all("discard.mid");
        end
        check_all("discard");
        chk("discard.raw", raw_out, 32'h0);
        chk("discard.wc", {16'd0, raw_wc}, 32'd1);

        // mixing with the LFSR
        do_reset();
        for (int i = 0; i < 32; i++) pair(1'b0, 1'b1);
        chk("mix1.const", mix_out, 32'hACE12468);
        for (int i = 0; i < 32; i++) pair(1'b0, 1'b1);
        chk("mix2.const", mix_out, 32'h56709234);
        check_all("mix2");

        // health trip on a stuck-at-1 source
        for (int i = 0; i < 32; i++) do_tick(1'b1);
        check_all("health");
        chk("health.fail", {31'd0, mix_fail}, 32'd1);
        chk("health.valid", {31'd0, mix_valid}, 32'd0);
        save_out = mix_out;
        save_wc = mix_wc;
        for (int i = 0; i < 40; i++) pair(1'b1, 1'b0);
        chk("health.hold_out", mix_out, save_out);
        chk("health.hold_wc", {16'd0, mix_wc}, {16'd0, save_wc});
        check_all("health.after");

        // enable drop discards a partial word
        do_reset();
        for (int i = 0; i < 32; i++) begin
            a = 1'($urandom_range(0, 1));
            pair(a, ~a);
        end
        check_all("drop.first");
        for (int i = 0; i < 10; i++) begin
            a = 1'($urandom_range(0, 1));
            pair(a, ~a);
        end
        drop_enable();
        save_out = raw_out;
        for (int i = 0; i < 31; i++) begin
            a = 1'($urandom_range(0, 1));
            pair(a, ~a);
        end
        chk("drop.held_out", raw_out, save_out);
        chk("drop.held_wc", {16'd0, raw_wc}, 32'd1);
        a = 1'($urandom_range(0, 1));
        pair(a, ~a);
        chk("drop.wc", {16'd0, raw_wc}, 32'd2);
        check_all("drop.done");

        // random bit stream with occasional enable drops
        do_reset();
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 24);
            if (r == 0) drop_enable();
            else do_tick(1'($urandom_range(0, 1)));
            check_all("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
